// File: rtl/seg7_scan_ctrl.sv
// Scan controller for an 8-digit multiplexed 7-segment display.
// Holds a 32-bit hex value and a control word; drives active-low digit enables and segments.
module seg7_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 20000,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n_i,
  input  logic        wr_en_i,
  input  logic        wr_addr_i,
  input  logic [31:0] wr_data_i,
  output logic [7:0]  led_en_o,
  output logic [7:0]  led_c_o,
  output logic [2:0]  digit_o
);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_BLANK,
    ST_SHOW
  } state_e;

  localparam logic [19:0] SHOW_LAST  = 20'(SCAN_DIV - 1);
  localparam logic [19:0] BLANK_LAST = 20'(BLANK_CYC - 1);
  // Only bits [16:0] of CTRL carry meaning, so the upper bits are never stored.
  localparam logic [16:0] CTRL_RST   = 17'h1_00FF;

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic [16:0] ctrl_q, ctrl_d;
  logic [7:0]  led_en_q, led_en_d;
  logic [7:0]  led_c_q, led_c_d;

  logic [7:0]  digit_mask;
  logic [7:0]  dp_mask;
  logic        disp_en;

  assign digit_mask = ctrl_q[7:0];
  assign dp_mask    = ctrl_q[15:8];
  assign disp_en    = ctrl_q[16];

  // Segment pattern {ca..cg,dp}, active-low, decimal point off.
  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] seg;
    unique case (nib)
      4'h0: seg = 8'h03;
      4'h1: seg = 8'h9F;
      4'h2: seg = 8'h25;
      4'h3: seg = 8'h0D;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h49;
      4'h6: seg = 8'h41;
      4'h7: seg = 8'h1F;
      4'h8: seg = 8'h01;
      4'h9: seg = 8'h09;
      4'hA: seg = 8'h11;
      4'hB: seg = 8'hC1;
      4'hC: seg = 8'h63;
      4'hD: seg = 8'h85;
      4'hE: seg = 8'h61;
      default: seg = 8'h71;
    endcase
    return seg;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    data_d   = data_q;
    ctrl_d   = ctrl_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    led_en_d = 8'hFF;
    led_c_d  = 8'hFF;

    if (wr_en_i) begin
      if (wr_addr_i) ctrl_d = wr_data_i[16:0];
      else           data_d = wr_data_i;
    end

    unique case (state_q)
      ST_OFF: begin
        if (disp_en) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      end
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: state_d = ST_OFF;
    endcase

    // Disable overrides any dwell-end transition decided above.
    if (!disp_en) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      idx_d   = '0;
    end

    // Outputs are registered from the next state so they line up with state_q.
    if (state_d == ST_SHOW && digit_mask[idx_d]) begin
      led_en_d = ~(8'h01 << idx_d);
      led_c_d  = hex_seg(data_q[{idx_d, 2'b00} +: 4]) & ~{7'b0, dp_mask[idx_d]};
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_BLANK;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      ctrl_q   <= CTRL_RST;
      led_en_q <= 8'hFF;
      led_c_q  <= 8'hFF;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      led_en_q <= led_en_d;
      led_c_q  <= led_c_d;
    end
  end

  assign led_en_o = led_en_q;
  assign led_c_o  = led_c_q;
  assign digit_o  = idx_q;

endmodule
